// File: rtl/screen_reader.sv
// Walks the Hack screen region word by word and serializes each word into
// single-pixel beats on a valid/ready stream, LSB (leftmost pixel) first.
module screen_reader #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned WORDS_PER_ROW = 32,
  parameter int unsigned ROWS          = 256,
  parameter int unsigned ADDR_W        = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              pixel_first,
  output logic              pixel_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned       CntW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0]   LastBit  = CntW'(WIDTH - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [ADDR_W-1:0] RowWords = ADDR_W'(WORDS_PER_ROW);

  typedef enum logic [1:0] {StIdle, StFetch, StShift} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              last_bit, last_word;

  assign last_bit  = (cnt_q == LastBit);
  assign last_word = (addr_q == LastAddr);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Word is captured here, so later CPU writes cannot disturb its beats.
        shift_d = mem_data;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        if (pixel_ready) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
          if (last_bit) begin
            if (last_word) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = StFetch;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // All outputs are decoded from registered state only; nothing depends on pixel_ready.
  always_comb begin
    pixel_valid = (state_q == StShift);
    pixel       = pixel_valid & shift_q[0];
    pixel_first = pixel_valid && (cnt_q == '0) && ((addr_q % RowWords) == '0);
    pixel_last  = pixel_valid && last_bit && last_word;
    busy        = (state_q != StIdle);
    frame_done  = done_q;
    mem_addr    = addr_q;
  end

endmodule

// File: tb/tb_screen_reader.sv
// Bench for screen_reader on a reduced frame geometry; beats are checked against
// a model derived from a snapshot of the screen RAM taken at frame start.
module tb_screen_reader;

  localparam int unsigned W    = 16;
  localparam int unsigned WPR  = 4;
  localparam int unsigned ROWS = 4;
  localparam int unsigned AW   = 13;
  localparam int unsigned NW   = WPR * ROWS;
  localparam int unsigned NB   = NW * W;

  logic          clk = 1'b0;
  logic          reset, start, pixel_ready;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          pixel, pixel_valid, pixel_first, pixel_last, busy, frame_done;

  logic [W-1:0]  ram  [2**AW];
  logic [W-1:0]  snap [NW];
  int            n_pass  = 0;
  int            n_total = 0;

  always #5 clk = ~clk;
  assign mem_data = ram[mem_addr];

  screen_reader #(
    .WIDTH(W), .WORDS_PER_ROW(WPR), .ROWS(ROWS), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mem_addr(mem_addr), .mem_data(mem_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .pixel_first(pixel_first), .pixel_last(pixel_last), .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected {pixel, first, last} for beat b of a frame.
  function automatic logic [2:0] exp_beat(input int b);
    int   w = b / W;
    int   i = b % W;
    logic p, f, l;
    if (w >= NW) return 3'bxxx;
    p = snap[w][i];
    f = (i == 0) && (w % WPR == 0);
    l = (w == NW - 1) && (i == W - 1);
    return {p, f, l};
  endfunction

  task automatic run_frame(input bit rand_ready, input int mid_start_beat, input bit chain,
                           input int poke_beat);
    int         beat = 0, cyc = 0, firsts = 0, lasts = 0;
    bit         got_done = 1'b0, stalled = 1'b0;
    logic [2:0] held = '0, cur;
    logic [W-1:0] word_acc = '0;
    for (int w = 0; w < NW; w++) snap[w] = ram[w];
    start = 1'b1;
    pixel_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("fetch_valid", 32'(pixel_valid), 0);
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_addr", 32'(mem_addr), 0);
    while (!got_done && cyc < 8 * NB + 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 2) chk("latency_valid", 32'(pixel_valid), 1);
      if (frame_done) begin
        got_done = 1'b1;
        if (!rand_ready) chk("done_cycle", cyc, 1 + NW * (W + 1));
        chk("done_beats", beat, NB);
      end else if (pixel_valid) begin
        cur = {pixel, pixel_first, pixel_last};
        if (stalled) chk("stall_hold", 32'(cur), 32'(held));
        chk("beat", 32'(cur), 32'(exp_beat(beat)));
        chk("beat_addr", 32'(mem_addr), beat / W);
        if (beat == poke_beat) ram[beat / W] = snap[beat / W] ^ 16'hFFFF;
        if (beat == mid_start_beat) start = 1'b1;
        pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pixel_ready) begin
          word_acc[beat % W] = pixel;
          firsts += int'(pixel_first);
          lasts  += int'(pixel_last);
          if (beat % W == W - 1) chk("word", 32'(word_acc), 32'(snap[beat / W]));
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = cur;
        end
      end else begin
        chk("gap_flags", {30'd0, pixel_first, pixel_last}, 0);
        chk("gap_busy", 32'(busy), 1);
      end
    end
    chk("done_seen", 32'(got_done), 1);
    chk("first_count", firsts, ROWS);
    chk("last_count", lasts, 1);
    pixel_ready = 1'b1;
    if (chain) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("chain_fetch_busy", 32'(busy), 1);
      chk("chain_fetch_valid", 32'(pixel_valid), 0);
      chk("chain_fetch_addr", 32'(mem_addr), 0);
      chk("chain_done_pulse", 32'(frame_done), 0);
      @(negedge clk);
      chk("chain_first_beat", {30'd0, pixel_valid, pixel_first}, 3);
    end else begin
      @(negedge clk);
      chk("done_pulse", 32'(frame_done), 0);
      chk("idle_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    pixel_ready = 1'b0;
    for (int i = 0; i < 2**AW; i++) ram[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(pixel_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_flags", {29'd0, pixel, pixel_first, pixel_last}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed pattern: word 0 = 0x0001, word 1 = 0x8000.
    ram[0] = 16'h0001;
    ram[1] = 16'h8000;
    run_frame(1'b0, -1, 1'b0, -1);

    // Address ramp, ignored mid-frame start, then restart in the frame_done cycle.
    for (int i = 0; i < NW; i++) ram[i] = 16'(i);
    run_frame(1'b0, 100, 1'b1, -1);

    // Reset in the middle of the chained frame.
    k = 0;
    while (!(pixel_valid && mem_addr == 5) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("reach_addr5", 32'(mem_addr), 5);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(pixel_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(frame_done), 0);
    chk("post_rst_busy", 32'(busy), 0);

    // Random data and backpressure, word 0 = 0xA5C3, word 2 rewritten while shifting.
    for (int i = 0; i < NW; i++) ram[i] = 16'($urandom);
    ram[0] = 16'hA5C3;
    run_frame(1'b1, -1, 1'b0, 2 * W + 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/screen_reader.md
Name: screen_reader

Overview:
- Read-side engine for the Hack screen memory map. The CPU writes 16-bit words into the screen region; this block walks that region in order and serializes each word into single-pixel beats.
- Output uses a valid/ready stream for a display or bench sink.
- Sits beside the screen RAM and drives its read address. The RAM read port is combinational: `mem_data` reflects `mem_addr` in the same cycle.

Parameters:
- WIDTH, 16, bits per screen word (pixels per word).
- WORDS_PER_ROW, 32, words per screen row (512 pixels).
- ROWS, 256, rows per frame.
- ADDR_W, 13, width of `mem_addr`. Must satisfy 2^ADDR_W >= WORDS_PER_ROW*ROWS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame scan; sampled only in IDLE.
- mem_addr  out  ADDR_W  word address into the screen region; registered.
- mem_data  in  WIDTH  screen word at `mem_addr`, valid the same cycle.
- pixel  out  1  current pixel bit (1 = black).
- pixel_valid  out  1  `pixel` and the flags below are valid.
- pixel_ready  in  1  sink accepts the beat when `pixel_valid` and `pixel_ready` are both high.
- pixel_first  out  1  beat is pixel 0 of a row.
- pixel_last  out  1  beat is the final pixel of the frame.
- busy  out  1  high in FETCH or SHIFT.
- frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted.

Behaviour:
- Reset (synchronous, active-high) sets:
  - state IDLE, `mem_addr` 0, shift register 0, bit counter 0;
  - `pixel`, `pixel_valid`, `pixel_first`, `pixel_last`, `busy`, `frame_done` all 0.
  - Reset mid-frame abandons the scan immediately. No `frame_done` is issued. The next `start` rescans from address 0.
- States:
  - IDLE: `busy`=0. If `start`=1, set `mem_addr` to 0 and go to FETCH. Otherwise stay in IDLE.
  - FETCH: load the shift register from `mem_data`, clear the bit counter, go to SHIFT. `pixel_valid`=0 in this cycle.
  - SHIFT:
    - `pixel_valid`=1 and `pixel` = shift register bit 0 (LSB is the leftmost pixel).
    - Each accepted beat shifts the register right by 1 and increments the bit counter.
    - While not accepted, `pixel` and all flags hold stable. No beat is dropped or repeated.
    - Accepted beat at bit counter = WIDTH-1, not the last word: increment `mem_addr`, go to FETCH.
    - Accepted beat at bit counter = WIDTH-1, last word (`mem_addr` = WORDS_PER_ROW*ROWS-1): go to IDLE and pulse `frame_done` in the next cycle. `mem_addr` holds its value.
- Flags:
  - `pixel_first` = 1 iff in SHIFT, bit counter = 0, and `mem_addr` mod WORDS_PER_ROW = 0.
  - `pixel_last` = 1 iff in SHIFT, bit counter = WIDTH-1, and `mem_addr` is the last word.
  - `pixel_first` and `pixel_last` are 0 whenever `pixel_valid`=0.
- Latency and throughput:
  - `start` in cycle t gives the first valid beat in cycle t+2 (t+1 is FETCH).
  - With `pixel_ready` held high: WIDTH beats per WIDTH+1 cycles. A full default frame takes 8192*17 = 139264 cycles from entering FETCH to `frame_done`.
- Handshake: `pixel_valid` never depends combinationally on `pixel_ready`. Once raised in SHIFT, it stays high until the beat is accepted.
- `start` while `busy`=1 is ignored. `start` in the same cycle as `frame_done` starts a new frame, because the state is already IDLE.
- `mem_data` is sampled only in FETCH. CPU writes to the word currently being shifted do not affect that word's beats.
- Address arithmetic is unsigned, ADDR_W bits, and never wraps within a frame.

Test Plan:
- Reset, then `start` pulse with `pixel_ready`=1, and a RAM model where word 0 = 16'h0001 and word 1 = 16'h8000 (rest 0):
  - first beat at t+2 has `pixel`=1 and `pixel_first`=1;
  - beats 1–15 are 0; beats 16–30 are 0; beat 31 = 1.
- Full frame with the RAM holding word k = k[15:0] and `pixel_ready`=1:
  - reassembled words match k for all 8192 words;
  - exactly 256 `pixel_first` beats, at beat indices that are multiples of 512;
  - `pixel_last` only on beat 131071;
  - `frame_done` one cycle later, at 139264 cycles after FETCH entry.
- Backpressure: `pixel_ready` toggled pseudo-randomly on word 0 = 16'hA5C3 →
  - `pixel` and flags stable while stalled;
  - accepted sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1.
- `start` pulsed at beat 100 mid-frame → ignored: `mem_addr` continues and the frame completes normally with one `frame_done`.
- `reset` asserted while in SHIFT at `mem_addr`=5 → next cycle:
  - state IDLE, `mem_addr`=0;
  - `pixel_valid`=0, `busy`=0;
  - no `frame_done`.
  A subsequent `start` emits word 0 first.
- `start` asserted in the `frame_done` cycle → second frame begins: FETCH next cycle, first beat two cycles after `start`.
